ex_mem_skid: RTL and testbench

Execute-to-memory pipeline boundary, placed directly downstream of the execute-stage ALU. Captures the ALU result, zero flag, store data and control bits for each instruction. Holds them in a two-entry skid buffer with a valid/ready handshake, so memory-stage back-pressure never creates a combinational path into execute. Also flags misaligned load/store addresses at capture time.

---
 rtl/ex_mem_skid.sv | 149 ++++++++++++++
 tb/tb_ex_mem_skid.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid.sv
// EX/MEM boundary: two-entry skid buffer between execute and memory.
// Optional stall counter enabled by defining EXMEM_PERF_EN.
module ex_mem_skid #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_zero,
  input  logic [WIDTH-1:0]      rs2_data,
  input  logic [WIDTH-1:0]      pc_plus4,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            result_src,
  input  logic [2:0]            funct3,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [WIDTH-1:0]      mem_alu_result,
  output logic                  mem_zero,
  output logic [WIDTH-1:0]      mem_rs2_data,
  output logic [WIDTH-1:0]      mem_pc_plus4,
  output logic [REG_ADDR_W-1:0] mem_rd_addr,
  output logic                  mem_reg_write,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic [1:0]            mem_result_src,
  output logic [2:0]            mem_funct3,
  output logic                  mem_misaligned,
  output logic [31:0]           stall_cycles
);

  typedef struct packed {
    logic [WIDTH-1:0]      alu;
    logic                  zero;
    logic [WIDTH-1:0]      rs2;
    logic [WIDTH-1:0]      pc4;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rw;
    logic                  mr;
    logic                  mw;
    logic [1:0]            src;
    logic [2:0]            f3;
    logic                  mis;
  } ent_t;

  ent_t head_q;
  ent_t skid_q;
  logic head_v;
  logic skid_v;
  ent_t in_e;
  logic mis;
  logic accept;
  logic pop;

  assign ex_ready  = !skid_v;
  assign mem_valid = head_v;
  assign accept    = ex_valid && !skid_v;
  assign pop       = head_v && mem_ready;

  // Bundle the incoming instruction and tag misaligned accesses.
  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      funct3[1:0] == 2'b01: mis = alu_result[0];
      funct3[1:0] == 2'b10: mis = |alu_result[1:0];
      default:              mis = 1'b0;
    endcase
    in_e      = '0;
    in_e.alu  = alu_result;
    in_e.zero = alu_zero;
    in_e.rs2  = rs2_data;
    in_e.pc4  = pc_plus4;
    in_e.rd   = rd_addr;
    in_e.rw   = reg_write;
    in_e.mr   = mem_read;
    in_e.mw   = mem_write;
    in_e.src  = result_src;
    in_e.f3   = funct3;
    in_e.mis  = (mem_read | mem_write) & mis;
  end

  // Head/skid update; flush kills valids but leaves data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_v <= 1'b0;
      skid_v <= 1'b0;
      head_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      head_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (pop && skid_v) begin
      head_q <= skid_q;
      skid_v <= accept;
      if (accept) begin
        skid_q <= in_e;
      end
    end else if (pop) begin
      head_v <= accept;
      if (accept) begin
        head_q <= in_e;
      end
    end else if (!head_v) begin
      head_v <= accept;
      if (accept) begin
        head_q <= in_e;
      end
    end else if (accept) begin
      skid_v <= 1'b1;
      skid_q <= in_e;
    end
  end

  assign mem_alu_result = head_q.alu;
  assign mem_zero       = head_q.zero;
  assign mem_rs2_data   = head_q.rs2;
  assign mem_pc_plus4   = head_q.pc4;
  assign mem_rd_addr    = head_q.rd;
  assign mem_reg_write  = head_q.rw;
  assign mem_mem_read   = head_q.mr;
  assign mem_mem_write  = head_q.mw;
  assign mem_result_src = head_q.src;
  assign mem_funct3     = head_q.f3;
  assign mem_misaligned = head_q.mis;

`ifdef EXMEM_PERF_EN
  logic [31:0] stall_q;

  // Saturating count of cycles the head waits on memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (head_v && !mem_ready && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Bench for ex_mem_skid: queue model plus directed literal checks.
// Random phase drives valid/ready/flush and compares every cycle.
module tb_ex_mem_skid;

  typedef struct packed {
    logic [31:0] alu;
    logic        zero;
    logic [31:0] rs2;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic        mis;
  } ent_t;

  logic        clk = 0;
  logic        rst_n;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] rs2_data;
  logic [31:0] pc_plus4;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  result_src;
  logic [2:0]  funct3;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_alu_result;
  logic        mem_zero;
  logic [31:0] mem_rs2_data;
  logic [31:0] mem_pc_plus4;
  logic [4:0]  mem_rd_addr;
  logic        mem_reg_write;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic [1:0]  mem_result_src;
  logic [2:0]  mem_funct3;
  logic        mem_misaligned;
  logic [31:0] stall_cycles;

  int nvec = 0;
  int nerr = 0;

  ent_t        q[$];
  logic [31:0] stall_m = 0;

  ex_mem_skid dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rs2_data(rs2_data), .pc_plus4(pc_plus4),
    .rd_addr(rd_addr), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write),
    .result_src(result_src), .funct3(funct3),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_alu_result(mem_alu_result), .mem_zero(mem_zero),
    .mem_rs2_data(mem_rs2_data), .mem_pc_plus4(mem_pc_plus4),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_result_src(mem_result_src), .mem_funct3(mem_funct3),
    .mem_misaligned(mem_misaligned), .stall_cycles(stall_cycles)
  );

  always #10 clk = ~clk;

  function automatic logic misal(logic [31:0] a, logic [2:0] f,
                                 logic rd, logic wr);
    int sz;
    if (!(rd || wr)) return 1'b0;
    sz = (f[1:0] == 2'd1) ? 2 : (f[1:0] == 2'd2) ? 4 : 1;
    return (a % sz) != 0;
  endfunction

  function automatic ent_t cur_in();
    ent_t e;
    e.alu  = alu_result;
    e.zero = alu_zero;
    e.rs2  = rs2_data;
    e.pc4  = pc_plus4;
    e.rd   = rd_addr;
    e.rw   = reg_write;
    e.mr   = mem_read;
    e.mw   = mem_write;
    e.src  = result_src;
    e.f3   = funct3;
    e.mis  = misal(alu_result, funct3, mem_read, mem_write);
    return e;
  endfunction

  // Reference: a FIFO of at most two entries.
  always @(posedge clk or negedge rst_n) begin
    int sz;
    if (!rst_n) begin
      q.delete();
      stall_m = 0;
    end else begin
      sz = q.size();
      if (sz > 0 && !mem_ready && stall_m != 32'hFFFF_FFFF)
        stall_m = stall_m + 1;
      if (flush) begin
        q.delete();
      end else begin
        if (sz > 0 && mem_ready) void'(q.pop_front());
        if (ex_valid && sz < 2) q.push_back(cur_in());
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    ent_t a;
    logic [31:0] es;
    a = '{mem_alu_result, mem_zero, mem_rs2_data, mem_pc_plus4,
          mem_rd_addr, mem_reg_write, mem_mem_read, mem_mem_write,
          mem_result_src, mem_funct3, mem_misaligned};
`ifdef EXMEM_PERF_EN
    es = stall_m;
`else
    es = 32'd0;
`endif
    chk("ex_ready", {31'd0, ex_ready}, {31'd0, q.size() < 2});
    chk("mem_valid", {31'd0, mem_valid}, {31'd0, q.size() > 0});
    chk("stall_cycles", stall_cycles, es);
    if (q.size() > 0) begin
      nvec++;
      if (a !== q[0]) begin
        nerr++;
        $display("FAIL head got %h want %h at %0t", a, q[0], $time);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic put(logic v, logic [31:0] a);
    ex_valid   = v;
    alu_result = a;
    alu_zero   = $urandom_range(0, 1);
    rs2_data   = $urandom;
    pc_plus4   = $urandom;
    rd_addr    = 5'($urandom);
    reg_write  = $urandom_range(0, 1);
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    result_src = 2'($urandom);
    funct3     = 3'd0;
  endtask

  initial begin
    rst_n = 1; flush = 0; mem_ready = 0;
    put(1'b1, 32'h77);
    #1 rst_n = 0;
    cyc(); cyc();
    chk("rst_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_alu", mem_alu_result, 32'd0);
    chk("rst_rd", {27'd0, mem_rd_addr}, 32'd0);
    chk("rst_mis", {31'd0, mem_misaligned}, 32'd0);
    rst_n = 1;
    put(1'b1, 32'h10); rd_addr = 5'd5; mem_ready = 1;
    cyc();
    chk("first_valid", {31'd0, mem_valid}, 32'd1);
    chk("first_alu", mem_alu_result, 32'h10);
    chk("first_rd", {27'd0, mem_rd_addr}, 32'd5);

    for (int i = 1; i <= 4; i++) begin
      put(1'b1, i);
      cyc();
      chk("stream_alu", mem_alu_result, i);
      chk("stream_ready", {31'd0, ex_ready}, 32'd1);
    end
    put(1'b0, 0); cyc();

    mem_ready = 0;
    put(1'b1, 32'hA); cyc();
    put(1'b1, 32'hB); cyc();
    chk("bp_ready", {31'd0, ex_ready}, 32'd0);
    put(1'b1, 32'hC); cyc();
    chk("bp_head", mem_alu_result, 32'hA);
    chk("bp_hold", {31'd0, ex_ready}, 32'd0);
    mem_ready = 1; cyc();
    chk("bp_b", mem_alu_result, 32'hB);
    cyc();
    chk("bp_c", mem_alu_result, 32'hC);
    put(1'b0, 0); cyc();
    chk("bp_empty", {31'd0, mem_valid}, 32'd0);

    mem_ready = 0;
    put(1'b1, 32'h21); cyc();
    put(1'b1, 32'h22); cyc();
    put(1'b1, 32'h99); flush = 1; cyc();
    chk("fl_valid", {31'd0, mem_valid}, 32'd0);
    chk("fl_ready", {31'd0, ex_ready}, 32'd1);
    flush = 0; put(1'b0, 0); mem_ready = 1;
    cyc();
    chk("fl_gone", {31'd0, mem_valid}, 32'd0);

    put(1'b1, 32'h1002); mem_write = 1; funct3 = 3'b010; cyc();
    chk("mis_word", {31'd0, mem_misaligned}, 32'd1);
    put(1'b1, 32'h1002); mem_write = 1; funct3 = 3'b001; cyc();
    chk("mis_half", {31'd0, mem_misaligned}, 32'd0);
    put(1'b1, 32'h1003); funct3 = 3'b001; cyc();
    chk("mis_nomem", {31'd0, mem_misaligned}, 32'd0);
    put(1'b1, 32'h1003); mem_read = 1; funct3 = 3'b001; cyc();
    chk("mis_ld_half", {31'd0, mem_misaligned}, 32'd1);

    mem_ready = 0;
    put(1'b1, 32'h31); cyc();
    put(1'b1, 32'h32); cyc();
    put(1'b1, 32'h33); cyc();
    rst_n = 0;
    #1;
    chk("ar_valid", {31'd0, mem_valid}, 32'd0);
    chk("ar_ready", {31'd0, ex_ready}, 32'd1);
    chk("ar_stall", stall_cycles, 32'd0);
    #1 rst_n = 1;
    put(1'b0, 0);
    cyc();

    for (int i = 0; i < 3000; i++) begin
      put($urandom_range(0, 9) < 7, $urandom);
      mem_read   = $urandom_range(0, 2) == 0;
      mem_write  = !mem_read && $urandom_range(0, 1);
      funct3     = {1'($urandom), 2'($urandom_range(0, 2))};
      mem_ready  = $urandom_range(0, 9) < 6;
      flush      = $urandom_range(0, 99) < 3;
      cyc();
    end
    flush = 0; put(1'b0, 0); mem_ready = 1;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
